// File: rtl/clk_div_int.sv
// rtl/clk_div_int.sv - runtime-programmable integer clock divider with glitch-free ratio changes
//
// Purpose: divides CLK by a runtime ratio N (DIV_RATIO). Ratios 0 and 1, a
// cleared enable, and reset all pass CLK straight through (bypass). For N>=2
// the output is low for ceil(N/2) cycles, then high for floor(N/2) cycles.
// A new ratio is only adopted at a period boundary, so a change mid-period
// can never produce a runt pulse.
//
// Optional build macro: CLK_DIV_PERIOD_TICK_EN adds PERIOD_TICK, a one-cycle
// registered pulse following every period boundary while dividing.
//
// Ports:
//   CLK          reference clock
//   RST          asynchronous active-low reset (deasserts synchronously to CLK)
//   CLK_EN       divider enable; low selects bypass
//   DIV_RATIO    requested division ratio N
//   DIV_CLK      divided clock, or CLK in bypass
//   PERIOD_TICK  period-boundary pulse (CLK_DIV_PERIOD_TICK_EN builds only)

module clk_div_int #(
    parameter int RATIO_WD = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLK_EN,
    input  logic [RATIO_WD-1:0] DIV_RATIO,
    output logic                DIV_CLK
`ifdef CLK_DIV_PERIOD_TICK_EN
    ,
    output logic                PERIOD_TICK
`endif
);

    // The longest phase is ceil((2^W-1)/2) = 2^(W-1) cycles, so a
    // W-1 bit counter holding (phase length - 1) is always wide enough.
    localparam int CW = RATIO_WD - 1;

    localparam logic [RATIO_WD-1:0] RATIO_ONE = RATIO_WD'(1);
    localparam logic [RATIO_WD-1:0] RATIO_TWO = RATIO_WD'(2);
    localparam logic [RATIO_WD:0]   X_ONE     = (RATIO_WD+1)'(1);
    localparam logic [CW-1:0]       CNT_ONE   = CW'(1);

    logic [CW-1:0]       cnt_q,   cnt_d;
    logic                div_q,   div_d;
    logic [RATIO_WD-1:0] ratio_q, ratio_d;
    logic                run_q,   run_d;

    logic                ratio_le1;
    logic                bypass;
    logic [RATIO_WD:0]   ratio_x;
    logic [RATIO_WD:0]   phase_len;
    logic [RATIO_WD:0]   phase_last;
    logic                at_end;

    assign ratio_le1 = (ratio_q <= RATIO_ONE);
    assign bypass    = !run_q || ratio_le1;

    // Low phase is the longer one for odd N: ceil(N/2) low, floor(N/2) high.
    assign ratio_x    = {1'b0, ratio_q};
    assign phase_len  = div_q ? (ratio_x >> 1) : ((ratio_x + X_ONE) >> 1);
    assign phase_last = phase_len - X_ONE;
    assign at_end     = (phase_last == {2'b00, cnt_q});

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        ratio_d = ratio_q;
        run_d   = run_q;
        if (!run_q) begin
            if (CLK_EN) begin
                run_d   = 1'b1;
                ratio_d = DIV_RATIO;
                cnt_d   = '0;
                div_d   = 1'b0;
            end
        end else if (!CLK_EN) begin
            // Dropping the enable wins over a boundary on the same edge;
            // truncating the current period is acceptable here.
            run_d = 1'b0;
            cnt_d = '0;
            div_d = 1'b0;
        end else if (ratio_le1) begin
            // While passing CLK through, every edge is a boundary, so a
            // newly requested N>=2 starts cleanly at the low phase.
            ratio_d = DIV_RATIO;
            cnt_d   = '0;
            div_d   = 1'b0;
        end else if (at_end) begin
            div_d = !div_q;
            cnt_d = '0;
            // High-to-low transition closes the period: adopt the new ratio.
            if (div_q) begin
                ratio_d = DIV_RATIO;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q   <= '0;
            div_q   <= 1'b0;
            ratio_q <= RATIO_ONE;
            run_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ratio_q <= ratio_d;
            run_q   <= run_d;
        end
    end

    // Combinational mux: in bypass and during reset the output is CLK itself.
    assign DIV_CLK = bypass ? CLK : div_q;

`ifdef CLK_DIV_PERIOD_TICK_EN
    logic tick_q, tick_d;

    // Pulse after a dividing boundary; suppressed when the ratio being loaded
    // puts the output into bypass, so the tick is never high in bypass.
    always_comb begin
        tick_d = 1'b0;
        if (run_q && CLK_EN && !ratio_le1 && at_end && div_q && (DIV_RATIO >= RATIO_TWO)) begin
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign PERIOD_TICK = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_int.sv
// tb/tb_clk_div_int.sv - self-checking bench for clk_div_int against a period-position model

module tb_clk_div_int;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [7:0] div_ratio;
    logic       div_clk;
`ifdef CLK_DIV_PERIOD_TICK_EN
    logic       period_tick;
`endif

    clk_div_int #(.RATIO_WD(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .CLK_EN    (clk_en),
        .DIV_RATIO (div_ratio),
        .DIV_CLK   (div_clk)
`ifdef CLK_DIV_PERIOD_TICK_EN
        ,
        .PERIOD_TICK (period_tick)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which ratio is active and where we are in its period.
    bit m_run       = 0;
    int m_ratio     = 1;
    int m_pos       = 0;
    bit m_tick_next = 0;
    int tick_cnt    = 0;

    bit hist[$];
    int run_len[$];
    bit run_val[$];

    function automatic bit m_bypass();
        return !m_run || (m_ratio <= 1);
    endfunction

    // Output level is high once the position passes the ceil(N/2) low cycles.
    function automatic bit m_level();
        return m_pos >= (m_ratio + 1) / 2;
    endfunction

    task automatic model_reset();
        m_run       = 0;
        m_ratio     = 1;
        m_pos       = 0;
        m_tick_next = 0;
    endtask

    task automatic model_edge();
        m_tick_next = 0;
        if (!m_run) begin
            if (clk_en) begin
                m_run   = 1;
                m_ratio = div_ratio;
                m_pos   = 0;
            end
        end else if (!clk_en) begin
            m_run = 0;
            m_pos = 0;
        end else if (m_ratio <= 1) begin
            m_ratio = div_ratio;
            m_pos   = 0;
        end else begin
            m_pos++;
            if (m_pos == m_ratio) begin
                m_pos       = 0;
                m_ratio     = div_ratio;
                m_tick_next = 1;
            end
        end
    endtask

    // One CLK cycle: advance the model on the edge, compare both half-cycles.
    task automatic step();
        logic exp;
        @(posedge clk);
        if (rst) model_edge();
        else m_tick_next = 0;
        #1;
        exp = m_bypass() ? clk : m_level();
        checks++;
        if (div_clk !== exp) begin
            errors++;
            $display("FAIL div_clk_high t=%0t got %b exp %b (ratio %0d pos %0d)", $time, div_clk, exp, m_ratio, m_pos);
        end
        hist.push_back(div_clk);
`ifdef CLK_DIV_PERIOD_TICK_EN
        checks++;
        if (period_tick !== (m_tick_next && !m_bypass())) begin
            errors++;
            $display("FAIL period_tick t=%0t got %b exp %b", $time, period_tick, (m_tick_next && !m_bypass()));
        end
        if (period_tick === 1'b1) tick_cnt++;
`endif
        @(negedge clk);
        #1;
        exp = m_bypass() ? clk : m_level();
        checks++;
        if (div_clk !== exp) begin
            errors++;
            $display("FAIL div_clk_low t=%0t got %b exp %b (ratio %0d pos %0d)", $time, div_clk, exp, m_ratio, m_pos);
        end
    endtask

    task automatic wait_pos(input int ratio, input int pos);
        int n;
        n = 0;
        while (!(m_run && m_ratio == ratio && m_pos == pos) && n < 600) begin
            step();
            n++;
        end
        checks++;
        if (n >= 600) begin
            errors++;
            $display("FAIL wait_pos timeout got ratio %0d pos %0d exp ratio %0d pos %0d", m_ratio, m_pos, ratio, pos);
        end
    endtask

    task automatic split_runs();
        run_len.delete();
        run_val.delete();
        for (int i = 0; i < hist.size(); i++) begin
            if (i == 0 || hist[i] != hist[i-1]) begin
                run_len.push_back(1);
                run_val.push_back(hist[i]);
            end else begin
                run_len[run_len.size()-1]++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 0;
        clk_en = 1;
        div_ratio = 8;
        model_reset();
        repeat (5) step();
        rst = 1;
        hist.delete();
        repeat (40) step();
        split_runs();
        checks++;
        if (run_len.size() < 8) begin
            errors++;
            $display("FAIL even_run_count got %0d exp >=8", run_len.size());
        end
        for (int i = 1; i < run_len.size() - 1; i++) begin
            checks++;
            if (run_len[i] != 4) begin
                errors++;
                $display("FAIL even_phase_len run %0d got %0d exp 4", i, run_len[i]);
            end
        end
    endtask

    task automatic test_odd();
        div_ratio = 5;
        repeat (10) step();
        hist.delete();
        repeat (30) step();
        split_runs();
        for (int i = 1; i < run_len.size() - 1; i++) begin
            checks++;
            if (run_len[i] != (run_val[i] ? 2 : 3)) begin
                errors++;
                $display("FAIL odd_phase_len run %0d level %0d got %0d exp %0d", i, run_val[i], run_len[i], run_val[i] ? 2 : 3);
            end
        end
    endtask

    task automatic test_ratio_change();
        div_ratio = 8;
        wait_pos(8, 0);
        wait_pos(8, 5);
        div_ratio = 6;
        hist.delete();
        repeat (30) step();
        split_runs();
        checks++;
        if (run_val[0] != 1'b1 || run_len[0] != 2) begin
            errors++;
            $display("FAIL change_tail got level %0d len %0d exp level 1 len 2", run_val[0], run_len[0]);
        end
        for (int i = 1; i < run_len.size() - 1; i++) begin
            checks++;
            if (run_len[i] != 3) begin
                errors++;
                $display("FAIL change_phase_len run %0d got %0d exp 3", i, run_len[i]);
            end
        end
    endtask

    task automatic test_bypass();
        div_ratio = 0;
        repeat (10) step();
        div_ratio = 1;
        repeat (4) step();
        div_ratio = 4;
        hist.delete();
        repeat (20) step();
        split_runs();
        checks++;
        if (run_val[0] != 1'b0 || run_len[0] != 2) begin
            errors++;
            $display("FAIL bypass_exit_first got level %0d len %0d exp level 0 len 2", run_val[0], run_len[0]);
        end
        for (int i = 1; i < run_len.size() - 1; i++) begin
            checks++;
            if (run_len[i] != 2) begin
                errors++;
                $display("FAIL bypass_exit_len run %0d got %0d exp 2", i, run_len[i]);
            end
        end
    endtask

    task automatic test_enable();
        div_ratio = 10;
        wait_pos(10, 6);
        clk_en = 0;
        step();
        checks++;
        if (dut.div_q !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_div_q got %b exp 0", dut.div_q);
        end
        repeat (3) step();
        clk_en = 1;
        hist.delete();
        repeat (14) step();
        split_runs();
        checks++;
        if (run_val[0] != 1'b0 || run_len[0] != 5 || run_len[1] != 5) begin
            errors++;
            $display("FAIL reenable_phases got low %0d high %0d (first level %0d) exp 5 5 level 0", run_len[0], run_len[1], run_val[0]);
        end
    endtask

    task automatic test_reset_mid();
        div_ratio = 7;
        wait_pos(7, 5);
        #1;
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (div_clk !== clk) begin
            errors++;
            $display("FAIL reset_mid_bypass got %b exp %b", div_clk, clk);
        end
        checks++;
        if (dut.ratio_q !== 8'd1 || dut.run_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state got ratio %0d run %b exp ratio 1 run 0", dut.ratio_q, dut.run_q);
        end
        repeat (3) step();
        rst = 1;
        repeat (20) step();
    endtask

`ifdef CLK_DIV_PERIOD_TICK_EN
    task automatic test_tick();
        div_ratio = 4;
        wait_pos(4, 0);
        tick_cnt = 0;
        repeat (40) step();
        checks++;
        if (tick_cnt != 10) begin
            errors++;
            $display("FAIL tick_count got %0d exp 10", tick_cnt);
        end
        div_ratio = 1;
        repeat (6) step();
        tick_cnt = 0;
        repeat (8) step();
        checks++;
        if (tick_cnt != 0) begin
            errors++;
            $display("FAIL tick_bypass got %0d exp 0", tick_cnt);
        end
    endtask
`endif

    task automatic test_random();
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 9) == 0) div_ratio = 8'($urandom_range(0, 255));
                else div_ratio = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 59) == 0) clk_en = !clk_en;
            step();
        end
        clk_en = 1;
        repeat (4) step();
    endtask

    initial begin
        rst = 0;
        clk_en = 0;
        div_ratio = 0;
        test_reset();
        test_odd();
        test_ratio_change();
        test_bypass();
        test_enable();
        test_reset_mid();
`ifdef CLK_DIV_PERIOD_TICK_EN
        test_tick();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_int.md
Name: clk_div_int

Overview:
- Runtime-programmable integer clock divider. It runs in one clock domain and is reset by that domain's synchronized active-low reset.
- Sits directly downstream of the per-domain reset synchronizer. Its RST input is the synchronizer's SYNC_RST, and its CLK is the same reference clock.
- Produces the divided clock for the UART TX/RX domains.
- Ratio changes are glitch-free: a new ratio takes effect only at a period boundary.

Parameters:
- RATIO_WD, 8, width of DIV_RATIO; legal ratios are 0..2^RATIO_WD-1.

Ports:
- CLK  input  1  reference clock.
- RST  input  1  reset, asynchronous, active-low. Driven from a reset synchronizer, so deassertion is synchronous to CLK.
- CLK_EN  input  1  divider enable; low selects bypass.
- DIV_RATIO  input  RATIO_WD  requested division ratio N.
- DIV_CLK  output  1  divided clock, or CLK in bypass.
- PERIOD_TICK  output  1  present only with CLK_DIV_PERIOD_TICK_EN (see Optional Feature).

Behaviour:
- Internal state:
  - cnt: RATIO_WD-1 bits.
  - div_q: 1 bit, divided clock register.
  - ratio_q: RATIO_WD bits, active ratio.
  - run: 1 bit, divider active.
- Reset (RST low, asynchronous): cnt=0, div_q=0, ratio_q=1, run=0.
  - DIV_CLK=CLK (bypass) for the whole time RST is low.
- Bypass condition: run==0, or ratio_q is 0 or 1.
  - In bypass, DIV_CLK=CLK through a combinational mux.
  - Otherwise DIV_CLK=div_q, a registered output.
- Start:
  - Rising edges are counted after RST is high.
  - On the first CLK rising edge with CLK_EN=1 and run=0: ratio_q<=DIV_RATIO, run<=1, cnt<=0, div_q<=0.
- Phase lengths for active ratio N>=2:
  - Low phase L: N/2 if N even, (N+1)/2 if N odd.
  - High phase H: N/2 if N even, (N-1)/2 if N odd.
  - Period = N CLK cycles. Odd N gives a duty of (N-1)/2N high.
- Counting (run=1, N>=2), each rising edge:
  - If cnt == current phase length-1: div_q toggles and cnt<=0.
  - Otherwise cnt increments.
- Period boundary: the edge where div_q goes 1->0, or any edge while ratio_q<=1 and run=1.
  - At that edge ratio_q<=DIV_RATIO.
  - A ratio change mid-period is ignored until the boundary, so there are no runt pulses.
- Leaving bypass:
  - When ratio_q<=1 and a boundary loads N>=2, the low phase starts with cnt=0 and div_q=0.
- CLK_EN falling:
  - On the first edge sampled with CLK_EN=0: run<=0, cnt<=0, div_q<=0, and the output switches to bypass immediately.
  - The current period may be truncated. This is accepted; downstream logic is held idle when the enable is off.
- Simultaneous events:
  - CLK_EN low takes priority over a period boundary.
  - RST low overrides everything, asynchronously.
- Reset mid-operation: all state returns to reset values at once, and DIV_CLK becomes CLK.

Optional Feature:
- Macro: CLK_DIV_PERIOD_TICK_EN.
- Defined:
  - PERIOD_TICK is a registered pulse, one CLK cycle wide. It asserts in the cycle following each period-boundary edge while run=1 and ratio_q>=2.
  - PERIOD_TICK is 0 in bypass and in reset.
  - UART prescaler logic uses it as a clock-enable alternative to DIV_CLK.
- Not defined: the port and its logic are absent.

Test Plan:
- Reset then even ratio: RST low 5 cycles, DIV_RATIO=8, CLK_EN=1, RST high.
  - DIV_CLK=CLK while RST is low.
  - After run sets: period 8 CLK cycles, low 4, high 4, continuous.
- Odd ratio: DIV_RATIO=5.
  - Low 3 / high 2 cycles, repeating every 5 cycles.
- Ratio change mid-period: running N=8, change to N=6 at cnt=1 of the high phase.
  - The current period completes as 8 cycles, then 6-cycle periods (3/3) follow.
  - No pulse is shorter than 3 cycles.
- Bypass values: DIV_RATIO=0, then 1.
  - DIV_CLK equals CLK in both cases.
  - Switching to DIV_RATIO=4 yields 2/2 cycles starting with the low phase.
- Enable and reset mid-operation:
  - N=10 with CLK_EN dropped in the high phase: next edge gives bypass, div_q=0.
  - Re-enable: restarts with the low phase of 5 cycles.
  - RST pulsed low mid-period: immediate bypass, and ratio_q reads 1.
- With CLK_DIV_PERIOD_TICK_EN, N=4: PERIOD_TICK is high for exactly 1 cycle every 4 cycles, and is 0 in bypass.
